video_vcrop: RTL
================

# video_vcrop

Vertical auto-crop stage directly downstream of `video_mux`. It consumes the registered RGB and sync/blank stream, measures the first active line and active-line count of each frame, and holds that window stable across frames. It then regenerates `vblank` so the scaler sees a fixed-height, centred picture. This removes vertical jitter in TIA titles that vary their VBLANK timing from frame to frame.

## Interface
Parameters:
- `VIS_NTSC`, 240: visible lines output in NTSC mode.
- `VIS_PAL`, 288: visible lines output in PAL mode.
- `STABLE_FRAMES`, 2: consecutive identical measurements required before the applied window changes.

Ports:
- `clk_sys` in 1: system clock. One clock; reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous active-low reset.
- `pix_ce` in 1: pixel enable, from `video_mux`.
- `hsync`, `vsync`, `hblank`, `vblank` in 1 each: input timing, from `video_mux`.
- `red`, `green`, `blue` in 8 each: input colour.
- `is_PAL` in 1: selects `VIS_PAL`/`VIS_NTSC`.
- `crop_en` in 1: 0 = pass-through, keeping the 1-pixel latency.
- `o_hsync`, `o_vsync`, `o_hblank`, `o_vblank` out 1 each: output timing.
- `o_red`, `o_green`, `o_blue` out 8 each: output colour.
- `o_pix_ce` out 1: `pix_ce` delayed by one `clk_sys`.

## Operation
- **Line counter** `line` (9 bit):
  - Advances on the rising edge of `hsync`, sampled on `pix_ce`.
  - Cleared on the rising edge of `vsync`.
  - Saturates at 511.
- **Measurement, per frame:**
  - `first_act` = `line` of the first line on which `vblank` is 0 during any `pix_ce`.
  - `act_cnt` = number of lines with `vblank` 0, saturating at 511.
- **Frame end** (`vsync` rising edge) computes the candidate start:
  - `cand = first_act + ((act_cnt - VIS) >> 1)` when `act_cnt > VIS`.
  - Otherwise `cand = first_act`.
  - Arithmetic is 10 bit; the result is clamped to 511.
- **Stabiliser FSM** has three states.
  - LOCKED:
    - `cand == applied` holds.
    - `cand != applied` → PENDING with `pend = cand`, `cnt = 1`.
  - PENDING:
    - `cand == pend` increments `cnt`.
    - When `cnt` reaches `STABLE_FRAMES`, `applied <= pend` → LOCKED.
    - `cand` differs from both `pend` and `applied` → `pend = cand`, `cnt = 1`.
    - `cand == applied` → LOCKED.
  - NOSIG, entered from any state when a frame has no active line:
    - `applied` is kept.
    - The first active frame → PENDING.
- **Window:** `win = crop_en && line >= applied && line < applied + VIS`.
  - `o_vblank = crop_en ? ~win : vblank`.
  - `o_hblank`, `o_hsync` and `o_vsync` pass through.
- **`is_PAL` toggle:** the stabiliser goes to PENDING with `cnt = 0`.
  - `applied` is reset to 16 (NTSC) or 24 (PAL).

## Timing
- All outputs are registered on `pix_ce`.
  - Latency is exactly one `pix_ce` for every output.
  - `o_pix_ce` lags `pix_ce` by one `clk_sys`.
- Reset values:
  - All colour outputs are 0.
  - `o_hsync` = 0, `o_vsync` = 0.
  - `o_hblank` = 1, `o_vblank` = 1.
  - `o_pix_ce` = 0.
- State after reset:
  - `applied` = 16, `line` = 0, FSM = PENDING with `cnt = 0`.
  - A reset mid-frame discards the partial measurement.
- The `applied` update is committed on the `pix_ce` that samples the `vsync` rising edge. It takes effect from line 0 of the next frame, never mid-frame.
- Simultaneous `vsync` and `hsync` rising on the same `pix_ce`: `vsync` wins and `line` becomes 0.
- A `vsync` pulse spanning multiple lines clears `line` once, on its rising edge.
- The window compare uses the 10-bit sum `applied + VIS`, so there is no wrap.

## Configuration
- `VCROP_BLACKEN_EN` defined:
  - Colour outputs are forced to 0 whenever `crop_en && !win`.
  - This guarantees black borders for scalers that ignore blanking.
- Not defined:
  - Colour passes through unconditionally.
  - Only `o_vblank` is regenerated.

## Structure
- Shared package `video_pkg`:
  - `typedef logic [8:0] line_t`.
  - Constants `VCROP_DEF_NTSC = 16`, `VCROP_DEF_PAL = 24`.
  - Stabiliser state enum `vcrop_state_e` (LOCKED, PENDING, NOSIG).
- Sub-module `vcrop_measure`:
  - Contains the line counter, `first_act`/`act_cnt` capture and the candidate computation.
  - Emits `cand`, `cand_valid` and `no_active` as a one-`pix_ce` pulse at frame end.
- The top level holds the FSM, window compare and output registers.

## Test plan
- **Steady NTSC:** `crop_en` = 1, 262-line frames, active lines 20–261 (`act_cnt` 242).
  - `cand` = 21.
  - After 2 frames `applied` = 21.
  - `o_vblank` is low for exactly lines 21–260.
- **Jitter rejection:** alternate `first_act` between 30 and 31 every frame, starting from `applied` = 30.
  - `applied` never changes.
  - `o_vblank` is identical in every frame.
- **Lock on a change:** `first_act` moves from 30 to 40 and stays there.
  - Frame 1: still 30.
  - Frame 2: `applied` = 40, taking effect from frame 3.
- **Blank frame:** one frame with `vblank` held at 1.
  - FSM goes to NOSIG.
  - `applied` is kept.
  - The next normal frame re-enters PENDING.
- **Pass-through and latency:** `crop_en` = 0, random RGB.
  - Outputs equal the inputs delayed by one `pix_ce`.
  - `o_vblank` follows `vblank`.
- **Reset and black borders:**
  - Assert `reset_n` low mid-frame: outputs go to their reset values immediately and `applied` = 16.
  - With `VCROP_BLACKEN_EN`, line 5 RGB = 0xFF/0xFF/0xFF outputs 0/0/0.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: shared types and constants for the video pipeline.
//   line_t          - 9-bit video line index
//   VCROP_DEF_NTSC  - default crop start line after reset / NTSC select
//   VCROP_DEF_PAL   - default crop start line after PAL select
//   vcrop_state_e   - vertical-crop stabiliser states
package video_pkg;
  typedef logic [8:0] line_t;

  localparam line_t VCROP_DEF_NTSC = 9'd16;
  localparam line_t VCROP_DEF_PAL  = 9'd24;
  localparam line_t LINE_MAX       = 9'd511;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    PENDING = 2'd1,
    NOSIG   = 2'd2
  } vcrop_state_e;
endpackage

// File: rtl/vcrop_measure.sv
// vcrop_measure: line counter and per-frame active-window measurement.
// Ports:
//   clk_i, rst_ni          - clock, async active-low reset
//   ce_i                   - pixel enable
//   hsync_i, vsync_i       - input sync (edges detected on ce_i)
//   vblank_i               - input vertical blank
//   vis_i                  - visible line count for the current standard
//   line_o                 - line index of the sample currently on the inputs
//   cand_o                 - candidate crop start of the frame just ended
//   cand_valid_o           - frame-end pulse, frame had active lines
//   no_active_o            - frame-end pulse, frame had no active line
module vcrop_measure
  import video_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       vblank_i,
  input  logic [9:0] vis_i,
  output line_t      line_o,
  output line_t      cand_o,
  output logic       cand_valid_o,
  output logic       no_active_o
);
  logic  hs_q, vs_q;
  line_t line_q, line_d;
  logic  seen_q;      // current line already counted as active
  logic  have_q;      // current frame has seen an active line
  logic  frame_ok_q;  // a full frame boundary has been seen since reset
  line_t first_q, cnt_q;

  logic  hs_rise, vs_rise, new_line, act;
  logic  seen_eff, have_eff;
  line_t cnt_eff;

  assign hs_rise  = hsync_i & ~hs_q;
  assign vs_rise  = vsync_i & ~vs_q;
  assign new_line = hs_rise | vs_rise;
  assign act      = ~vblank_i;

  // The sample carrying a sync edge already belongs to the new line, so the
  // line index is resolved combinationally; vsync takes priority over hsync.
  always_comb begin
    line_d = line_q;
    if (vs_rise)                          line_d = '0;
    else if (hs_rise && line_q != LINE_MAX) line_d = line_q + 9'd1;
  end
  assign line_o = line_d;

  // Frame-boundary sample starts a fresh measurement including itself.
  assign seen_eff = new_line ? 1'b0 : seen_q;
  assign have_eff = vs_rise  ? 1'b0 : have_q;
  assign cnt_eff  = vs_rise  ? '0   : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      line_q     <= '0;
      seen_q     <= 1'b0;
      have_q     <= 1'b0;
      frame_ok_q <= 1'b0;
      first_q    <= '0;
      cnt_q      <= '0;
    end else if (ce_i) begin
      hs_q   <= hsync_i;
      vs_q   <= vsync_i;
      line_q <= line_d;
      seen_q <= seen_eff | act;
      have_q <= have_eff | act;
      if (act && !have_eff) first_q <= line_d;
      if (act && !seen_eff && cnt_eff != LINE_MAX) cnt_q <= cnt_eff + 9'd1;
      else                                         cnt_q <= cnt_eff;
      if (vs_rise) frame_ok_q <= 1'b1;
    end
  end

  // Centre an oversized window; 10-bit sum cannot overflow (511+135).
  logic [9:0] excess, sum;
  always_comb begin
    excess = {1'b0, cnt_q} - vis_i;
    sum    = {1'b0, first_q};
    if ({1'b0, cnt_q} > vis_i) sum = {1'b0, first_q} + (excess >> 1);
    cand_o = sum[9] ? LINE_MAX : sum[8:0];
  end

  // The partial frame in flight at reset is never reported.
  assign cand_valid_o = ce_i & vs_rise & frame_ok_q &  have_q;
  assign no_active_o  = ce_i & vs_rise & frame_ok_q & ~have_q;
endmodule

// File: rtl/video_vcrop.sv
// video_vcrop: vertical auto-crop. Measures the active window of each frame,
// stabilises the start line over STABLE_FRAMES frames and regenerates vblank
// for a fixed-height centred picture.
// Optional build macro: VCROP_BLACKEN_EN - force colour to 0 outside the
// window while cropping (default: colour passes through).
// Ports:
//   clk_sys, reset_n                   - clock, async active-low reset
//   pix_ce                             - pixel enable
//   hsync/vsync/hblank/vblank          - input timing
//   red/green/blue                     - input colour
//   is_PAL                             - selects VIS_PAL / VIS_NTSC
//   crop_en                            - 0 = pass-through
//   o_hsync/o_vsync/o_hblank/o_vblank  - output timing (1 pix_ce latency)
//   o_red/o_green/o_blue               - output colour (1 pix_ce latency)
//   o_pix_ce                           - pix_ce delayed one clk_sys
module video_vcrop
  import video_pkg::*;
#(
  parameter int VIS_NTSC      = 240,
  parameter int VIS_PAL       = 288,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pix_ce,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       is_PAL,
  input  logic       crop_en,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_hblank,
  output logic       o_vblank,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic       o_pix_ce
);
  localparam logic [7:0] STAB   = 8'(STABLE_FRAMES);
  // With a threshold of 1 a single new measurement is applied at once.
  localparam logic       INSTANT = (STAB <= 8'd1);

  logic [9:0] vis;
  assign vis = is_PAL ? 10'(VIS_PAL) : 10'(VIS_NTSC);

  line_t line, cand;
  logic  cand_valid, no_active;

  vcrop_measure u_meas (
    .clk_i        (clk_sys),
    .rst_ni       (reset_n),
    .ce_i         (pix_ce),
    .hsync_i      (hsync),
    .vsync_i      (vsync),
    .vblank_i     (vblank),
    .vis_i        (vis),
    .line_o       (line),
    .cand_o       (cand),
    .cand_valid_o (cand_valid),
    .no_active_o  (no_active)
  );

  // ---------------- stabiliser FSM ----------------
  vcrop_state_e state_q, state_d;
  line_t        applied_q, applied_d, pend_q, pend_d;
  logic [7:0]   cnt_q, cnt_d, cnt_nxt;
  logic         pal_q, pal_tgl, commit;

  assign pal_tgl = is_PAL ^ pal_q;
  assign cnt_nxt = (cand == pend_q) ? cnt_q + 8'd1 : 8'd1;
  assign commit  = cnt_nxt >= STAB;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= PENDING;
      applied_q <= VCROP_DEF_NTSC;
      pend_q    <= VCROP_DEF_NTSC;
      cnt_q     <= '0;
      pal_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      applied_q <= applied_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      pal_q     <= is_PAL;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pal_tgl)        state_d = PENDING;
    else if (no_active) state_d = NOSIG;
    else if (cand_valid) begin
      case (state_q)
        LOCKED:  if (cand != applied_q) state_d = INSTANT ? LOCKED : PENDING;
        PENDING: if (cand == applied_q || commit) state_d = LOCKED;
        NOSIG:   state_d = INSTANT ? LOCKED : PENDING;
        default: state_d = PENDING;
      endcase
    end
  end

  // applied only moves on a frame-end pulse (the vsync-edge sample), so the
  // new window starts with line 0 of the following frame.
  always_comb begin
    applied_d = applied_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    if (pal_tgl) begin
      applied_d = is_PAL ? VCROP_DEF_PAL : VCROP_DEF_NTSC;
      pend_d    = applied_d;
      cnt_d     = '0;
    end else if (cand_valid) begin
      case (state_q)
        PENDING: begin
          if (cand == applied_q) cnt_d = '0;
          else begin
            pend_d = cand;
            cnt_d  = cnt_nxt;
            if (commit) applied_d = cand;
          end
        end
        default: begin
          if (state_q == NOSIG || cand != applied_q) begin
            pend_d = cand;
            cnt_d  = 8'd1;
            if (INSTANT) applied_d = cand;
          end
        end
      endcase
    end
  end

  // ---------------- window and outputs ----------------
  logic win, blk;
  assign win = crop_en && (line >= applied_q) &&
               ({1'b0, line} < ({1'b0, applied_q} + vis));

`ifdef VCROP_BLACKEN_EN
  assign blk = crop_en & ~win;
`else
  assign blk = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      o_hsync  <= 1'b0;
      o_vsync  <= 1'b0;
      o_hblank <= 1'b1;
      o_vblank <= 1'b1;
      o_red    <= '0;
      o_green  <= '0;
      o_blue   <= '0;
      o_pix_ce <= 1'b0;
    end else begin
      o_pix_ce <= pix_ce;
      if (pix_ce) begin
        o_hsync  <= hsync;
        o_vsync  <= vsync;
        o_hblank <= hblank;
        o_vblank <= crop_en ? ~win : vblank;
        o_red    <= blk ? 8'h00 : red;
        o_green  <= blk ? 8'h00 : green;
        o_blue   <= blk ? 8'h00 : blue;
      end
    end
  end
endmodule
